regfile_param: RTL and testbench

REGFILE_PARAM -- requirements
Module: regfile_param

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_entry.sv | 42 ++++
 rtl/regfile_param.sv | 119 +++++++++++
 tb/tb_regfile_param.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the parameterised register file.
package regfile_pkg;

  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefDepth = 8;

  // Address width for a given register count; never narrower than one bit.
  function automatic int unsigned calc_aw(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/regfile_entry.sv
// One register-file entry: a data word plus its pending (scoreboard) bit.
module regfile_entry
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  input  logic              set,
  output logic [DATA_W-1:0] data,
  output logic              pending
);

  logic [DATA_W-1:0] data_q;
  logic              pending_q;

  // Data word: loads on any enabled write, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else if (we) begin
      data_q <= wdata;
    end
  end

  // Pending bit: an alloc (set) beats a same-cycle write (clear).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= 1'b0;
    end else if (set) begin
      pending_q <= 1'b1;
    end else if (we) begin
      pending_q <= 1'b0;
    end
  end

  assign data    = data_q;
  assign pending = pending_q;

endmodule

// File: rtl/regfile_param.sv
// Two-write / two-read register file with optional zero register, write-to-read
// bypass and a per-entry pending scoreboard.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned DEPTH    = DefDepth,
  parameter bit          ZERO_REG = 1'b0,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned AW      = calc_aw(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we0,
  input  logic              we1,
  input  logic [AW-1:0]     waddr0,
  input  logic [AW-1:0]     waddr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [AW-1:0]     raddr0,
  input  logic [AW-1:0]     raddr1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              rbusy0,
  output logic              rbusy1,
  input  logic              alloc,
  input  logic [AW-1:0]     alloc_addr,
  output logic              alloc_err,
  output logic [DEPTH-1:0]  busy_vec
);

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  pending_q;
  logic              wr0_ok, wr1_ok, alloc_ok;
  logic              alloc_err_q, alloc_err_d;

  // Entry 0 swallows writes and allocs when it is hard-wired to zero.
  assign wr0_ok   = we0 && !(ZERO_REG && (waddr0 == '0));
  assign wr1_ok   = we1 && !(ZERO_REG && (waddr1 == '0));
  assign alloc_ok = alloc && !(ZERO_REG && (alloc_addr == '0));

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic              hit0, hit1;
    logic [DATA_W-1:0] ent_wdata;

    assign hit0      = wr0_ok && (waddr0 == AW'(i));
    assign hit1      = wr1_ok && (waddr1 == AW'(i));
    // Port 1 wins a same-address collision.
    assign ent_wdata = hit1 ? wdata1 : wdata0;

    regfile_entry #(
      .DATA_W (DATA_W)
    ) u_entry (
      .clk     (clk),
      .rst     (rst),
      .we      (hit0 || hit1),
      .wdata   (ent_wdata),
      .set     (alloc_ok && (alloc_addr == AW'(i))),
      .data    (data_q[i]),
      .pending (pending_q[i])
    );
  end

  // Read port 0: stored value, optionally overridden by same-cycle write data.
  always_comb begin
    rdata0 = data_q[raddr0];
    rbusy0 = pending_q[raddr0];
    if (BYPASS) begin
      if (wr1_ok && (waddr1 == raddr0)) begin
        rdata0 = wdata1;
        rbusy0 = 1'b0;
      end else if (wr0_ok && (waddr0 == raddr0)) begin
        rdata0 = wdata0;
        rbusy0 = 1'b0;
      end
    end
    if (ZERO_REG && (raddr0 == '0)) rdata0 = '0;
    if (rst) begin
      rdata0 = '0;
      rbusy0 = 1'b0;
    end
  end

  // Read port 1: same structure as port 0.
  always_comb begin
    rdata1 = data_q[raddr1];
    rbusy1 = pending_q[raddr1];
    if (BYPASS) begin
      if (wr1_ok && (waddr1 == raddr1)) begin
        rdata1 = wdata1;
        rbusy1 = 1'b0;
      end else if (wr0_ok && (waddr0 == raddr1)) begin
        rdata1 = wdata0;
        rbusy1 = 1'b0;
      end
    end
    if (ZERO_REG && (raddr1 == '0)) rdata1 = '0;
    if (rst) begin
      rdata1 = '0;
      rbusy1 = 1'b0;
    end
  end

  // Allocating an already-pending entry is an error, reported one cycle later.
  assign alloc_err_d = alloc_ok && pending_q[alloc_addr];

  // Registered one-cycle error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alloc_err_q <= 1'b0;
    end else begin
      alloc_err_q <= alloc_err_d;
    end
  end

  assign alloc_err = alloc_err_q;
  assign busy_vec  = pending_q;

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench: three register-file variants (default, no bypass,
// zero register) share one stimulus stream; expectations go through a queue.
module tb_regfile_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       we0, we1, alloc;
  logic [2:0] waddr0, waddr1, raddr0, raddr1, alloc_addr;
  logic [7:0] wdata0, wdata1;

  logic [7:0] a_rd0, a_rd1, b_rd0, b_rd1, z_rd0, z_rd1;
  logic       a_rb0, a_rb1, b_rb0, b_rb1, z_rb0, z_rb1;
  logic       a_err, b_err, z_err;
  logic [7:0] a_bv, b_bv, z_bv;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  regfile_param #(.DATA_W(8), .DEPTH(8), .ZERO_REG(1'b0), .BYPASS(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .we0(we0), .we1(we1), .waddr0(waddr0), .waddr1(waddr1),
    .wdata0(wdata0), .wdata1(wdata1), .raddr0(raddr0), .raddr1(raddr1),
    .rdata0(a_rd0), .rdata1(a_rd1), .rbusy0(a_rb0), .rbusy1(a_rb1), .alloc(alloc),
    .alloc_addr(alloc_addr), .alloc_err(a_err), .busy_vec(a_bv)
  );

  regfile_param #(.DATA_W(8), .DEPTH(8), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .we0(we0), .we1(we1), .waddr0(waddr0), .waddr1(waddr1),
    .wdata0(wdata0), .wdata1(wdata1), .raddr0(raddr0), .raddr1(raddr1),
    .rdata0(b_rd0), .rdata1(b_rd1), .rbusy0(b_rb0), .rbusy1(b_rb1), .alloc(alloc),
    .alloc_addr(alloc_addr), .alloc_err(b_err), .busy_vec(b_bv)
  );

  regfile_param #(.DATA_W(8), .DEPTH(8), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut_z (
    .clk(clk), .rst(rst), .we0(we0), .we1(we1), .waddr0(waddr0), .waddr1(waddr1),
    .wdata0(wdata0), .wdata1(wdata1), .raddr0(raddr0), .raddr1(raddr1),
    .rdata0(z_rd0), .rdata1(z_rd1), .rbusy0(z_rb0), .rbusy1(z_rb1), .alloc(alloc),
    .alloc_addr(alloc_addr), .alloc_err(z_err), .busy_vec(z_bv)
  );

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; alloc = 1'b0;
    waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
    raddr0 = '0; raddr1 = '0; alloc_addr = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] got [12];
    logic [7:0] exp;
    for (int i = 1; i < 8; i++) begin
      we0 = 1'b1; waddr0 = 3'(i); wdata0 = 8'($urandom_range(1, 255));
      step();
    end
    idle();
    alloc = 1'b1; alloc_addr = 3'd6;
    step();
    step();
    idle();
    exp_q.push_back(8'h01);
    #1;
    exp = exp_q.pop_front(); vectors++;
    if (8'(a_err) !== exp) begin
      $display("FAIL reset_prior_err: got %0h, expected %0h", a_err, exp); miscompares++;
    end
    // Assert reset between edges with a bypassing write in flight.
    rst = 1'b1; we0 = 1'b1; waddr0 = 3'd6; wdata0 = 8'hAB; raddr0 = 3'd6; raddr1 = 3'd3;
    for (int k = 0; k < 12; k++) exp_q.push_back(8'h00);
    #1;
    got = '{a_rd0, a_rd1, b_rd0, b_rd1, z_rd0, z_rd1, a_bv, b_bv, z_bv,
            8'(a_err), 8'(b_err), 8'(z_err)};
    foreach (got[k]) begin
      exp = exp_q.pop_front(); vectors++;
      if (got[k] !== exp) begin
        $display("FAIL reset_async[%0d]: got %0h, expected %0h", k, got[k], exp); miscompares++;
      end
    end
    alloc = 1'b1; alloc_addr = 3'd2;
    step();
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    got[0] = a_rd0; got[1] = a_bv;
    for (int k = 0; k < 2; k++) begin
      exp = exp_q.pop_front(); vectors++;
      if (got[k] !== exp) begin
        $display("FAIL reset_held[%0d]: got %0h, expected %0h", k, got[k], exp); miscompares++;
      end
    end
    rst = 1'b0;
    we0 = 1'b1; waddr0 = 3'd1; wdata0 = 8'h33; alloc = 1'b1; alloc_addr = 3'd2;
    exp_q.push_back(8'h33); exp_q.push_back(8'h33); exp_q.push_back(8'h04);
    exp_q.push_back(8'h00);
    step();
    idle();
    raddr0 = 3'd1;
    #1;
    got[0] = a_rd0; got[1] = b_rd0; got[2] = a_bv; got[3] = 8'(a_err);
    for (int k = 0; k < 4; k++) begin
      exp = exp_q.pop_front(); vectors++;
      if (got[k] !== exp) begin
        $display("FAIL reset_release[%0d]: got %0h, expected %0h", k, got[k], exp); miscompares++;
      end
    end
    we0 = 1'b1; waddr0 = 3'd2;
    step();
    idle();
  endtask

  task automatic test_collision();
    logic [7:0] got [3];
    logic [7:0] exp;
    we0 = 1'b1; we1 = 1'b1; waddr0 = 3'd3; waddr1 = 3'd3; wdata0 = 8'h11; wdata1 = 8'h22;
    for (int k = 0; k < 3; k++) exp_q.push_back(8'h22);
    step();
    idle();
    raddr0 = 3'd3;
    #1;
    got = '{a_rd0, b_rd0, z_rd0};
    foreach (got[k]) begin
      exp = exp_q.pop_front(); vectors++;
      if (got[k] !== exp) begin
        $display("FAIL collision[%0d]: got %0h, expected %0h", k, got[k], exp); miscompares++;
      end
    end
  endtask

  task automatic test_bypass();
    logic [7:0] got [3];
    logic [7:0] exp;
    we0 = 1'b1; waddr0 = 3'd2; wdata0 = 8'h10;
    step();
    idle();
    we0 = 1'b1; waddr0 = 3'd2; wdata0 = 8'h5A; raddr0 = 3'd2;
    exp_q.push_back(8'h5A); exp_q.push_back(8'h10); exp_q.push_back(8'h5A);
    #1;
    got = '{a_rd0, b_rd0, z_rd0};
    foreach (got[k]) begin
      exp = exp_q.pop_front(); vectors++;
      if (got[k] !== exp) begin
        $display("FAIL bypass_same_cycle[%0d]: got %0h, expected %0h", k, got[k], exp);
        miscompares++;
      end
    end
    exp_q.push_back(8'h5A);
    step();
    idle();
    raddr0 = 3'd2;
    #1;
    exp = exp_q.pop_front(); vectors++;
    if (b_rd0 !== exp) begin
      $display("FAIL bypass_after_edge: got %0h, expected %0h", b_rd0, exp); miscompares++;
    end
    we0 = 1'b1; we1 = 1'b1; waddr0 = 3'd2; waddr1 = 3'd2; wdata0 = 8'h01; wdata1 = 8'h02;
    raddr1 = 3'd2;
    exp_q.push_back(8'h02); exp_q.push_back(8'h5A);
    #1;
    got[0] = a_rd1; got[1] = b_rd1;
    for (int k = 0; k < 2; k++) begin
      exp = exp_q.pop_front(); vectors++;
      if (got[k] !== exp) begin
        $display("FAIL bypass_priority[%0d]: got %0h, expected %0h", k, got[k], exp);
        miscompares++;
      end
    end
    step();
    idle();
  endtask

  task automatic test_scoreboard();
    logic [7:0] got [3];
    logic [7:0] exp;
    alloc = 1'b1; alloc_addr = 3'd5;
    exp_q.push_back(8'h01); exp_q.push_back(8'h01); exp_q.push_back(8'h01);
    step();
    idle();
    raddr0 = 3'd5;
    #1;
    got = '{8'(a_bv[5]), 8'(a_rb0), 8'(b_rb0)};
    foreach (got[k]) begin
      exp = exp_q.pop_front(); vectors++;
      if (got[k] !== exp) begin
        $display("FAIL sb_alloc[%0d]: got %0h, expected %0h", k, got[k], exp); miscompares++;
      end
    end
    we1 = 1'b1; waddr1 = 3'd5; wdata1 = 8'h42; raddr1 = 3'd5;
    exp_q.push_back(8'h00); exp_q.push_back(8'h01);
    #1;
    got[0] = 8'(a_rb1); got[1] = 8'(b_rb1);
    for (int k = 0; k < 2; k++) begin
      exp = exp_q.pop_front(); vectors++;
      if (got[k] !== exp) begin
        $display("FAIL sb_rbusy_bypass[%0d]: got %0h, expected %0h", k, got[k], exp);
        miscompares++;
      end
    end
    exp_q.push_back(8'h00);
    step();
    idle();
    exp = exp_q.pop_front(); vectors++;
    if (8'(a_bv[5]) !== exp) begin
      $display("FAIL sb_write_clear: got %0h, expected %0h", a_bv[5], exp); miscompares++;
    end
    alloc = 1'b1; alloc_addr = 3'd5; we0 = 1'b1; waddr0 = 3'd5; wdata0 = 8'h43;
    exp_q.push_back(8'h01); exp_q.push_back(8'h00);
    step();
    idle();
    got[0] = 8'(a_bv[5]); got[1] = 8'(a_err);
    for (int k = 0; k < 2; k++) begin
      exp = exp_q.pop_front(); vectors++;
      if (got[k] !== exp) begin
        $display("FAIL sb_set_wins[%0d]: got %0h, expected %0h", k, got[k], exp); miscompares++;
      end
    end
    we0 = 1'b1; waddr0 = 3'd5; wdata0 = 8'h44;
    step();
    idle();
  endtask

  task automatic test_double_alloc();
    logic [7:0] got [2];
    logic [7:0] exp;
    alloc = 1'b1; alloc_addr = 3'd4;
    exp_q.push_back(8'h00);
    step();
    exp = exp_q.pop_front(); vectors++;
    if (8'(a_err) !== exp) begin
      $display("FAIL dalloc_first: got %0h, expected %0h", a_err, exp); miscompares++;
    end
    exp_q.push_back(8'h01); exp_q.push_back(8'h01);
    step();
    idle();
    got = '{8'(a_err), 8'(b_err)};
    foreach (got[k]) begin
      exp = exp_q.pop_front(); vectors++;
      if (got[k] !== exp) begin
        $display("FAIL dalloc_pulse[%0d]: got %0h, expected %0h", k, got[k], exp); miscompares++;
      end
    end
    exp_q.push_back(8'h00); exp_q.push_back(8'h01);
    step();
    got = '{8'(a_err), 8'(a_bv[4])};
    foreach (got[k]) begin
      exp = exp_q.pop_front(); vectors++;
      if (got[k] !== exp) begin
        $display("FAIL dalloc_after[%0d]: got %0h, expected %0h", k, got[k], exp); miscompares++;
      end
    end
    we0 = 1'b1; waddr0 = 3'd4; wdata0 = 8'h99;
    step();
    idle();
  endtask

  task automatic test_zero_reg();
    logic [7:0] got [5];
    logic [7:0] exp;
    we0 = 1'b1; waddr0 = 3'd0; wdata0 = 8'hFF; alloc = 1'b1; alloc_addr = 3'd0; raddr0 = 3'd0;
    exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
    #1;
    got[0] = z_rd0; got[1] = a_rd0;
    for (int k = 0; k < 2; k++) begin
      exp = exp_q.pop_front(); vectors++;
      if (got[k] !== exp) begin
        $display("FAIL zero_same_cycle[%0d]: got %0h, expected %0h", k, got[k], exp);
        miscompares++;
      end
    end
    exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h01);
    step();
    idle();
    raddr0 = 3'd0;
    #1;
    got = '{z_rd0, 8'(z_bv[0]), 8'(z_err), a_rd0, 8'(a_bv[0])};
    foreach (got[k]) begin
      exp = exp_q.pop_front(); vectors++;
      if (got[k] !== exp) begin
        $display("FAIL zero_addr0[%0d]: got %0h, expected %0h", k, got[k], exp); miscompares++;
      end
    end
    we0 = 1'b1; waddr0 = 3'd1; wdata0 = 8'hFF; alloc = 1'b1; alloc_addr = 3'd1;
    exp_q.push_back(8'hFF); exp_q.push_back(8'h01); exp_q.push_back(8'h00);
    step();
    idle();
    raddr0 = 3'd1;
    #1;
    got[0] = z_rd0; got[1] = 8'(z_bv[1]); got[2] = 8'(z_err);
    for (int k = 0; k < 3; k++) begin
      exp = exp_q.pop_front(); vectors++;
      if (got[k] !== exp) begin
        $display("FAIL zero_addr1[%0d]: got %0h, expected %0h", k, got[k], exp); miscompares++;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_collision();
    test_bypass();
    test_scoreboard();
    test_double_alloc();
    test_zero_reg();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
